gpu_req_arb_buffer: RTL and testbench
=====================================

Name: gpu_req_arb_buffer

Overview:
- Parametrised successor to the single-channel GPU request bundle.
- Takes NUM_REQS independent GPU-request channels, each with a valid/ready handshake, and arbitrates them round-robin.
- Discards zero-thread-mask requests, and buffers the rest in a DEPTH-entry FIFO in front of the GPU unit.
- Sits between the issue/dispatch stage and the GPU unit, and adds flush and performance counters.

Parameters:
- NUM_REQS, 4, number of input channels (≥1)
- NUM_THREADS, 4, threads per warp (width of tmask)
- REQ_DATAW, computed in package, packed payload width: uuid, wid, PC, next_PC, op_type, op_mod, tid, rs1/rs2/rs3 data, rd, wb
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SEL_W, max(1,clog2(NUM_REQS)), source-channel index width
- CNT_W, clog2(DEPTH+1), occupancy width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous FIFO clear
- in_valid  in  NUM_REQS  per-channel request valid
- in_tmask  in  NUM_REQS*NUM_THREADS  per-channel thread mask
- in_data  in  NUM_REQS*REQ_DATAW  per-channel packed payload
- in_ready  out  NUM_REQS  per-channel accept (at most one bit set)
- out_valid  out  1  head entry valid
- out_tmask  out  NUM_THREADS  head thread mask
- out_data  out  REQ_DATAW  head payload
- out_sel  out  SEL_W  source channel of head entry
- out_ready  in  1  GPU unit accepts head
- count  out  CNT_W  FIFO occupancy
- perf_stall  out  32  cycles with ≥1 in_valid and no accept
- perf_drop  out  32  zero-tmask requests discarded

Behaviour:
- Reset (reset_n=0, async):
  - count=0, rd/wr pointers=0, rr pointer=NUM_REQS-1 (channel 0 first).
  - perf counters=0, in_ready=0, out_valid=0.
  - Reset mid-operation loses all entries.
- Arbitration (combinational):
  - Candidates are the in_valid bits. Priority starts at rr+1 mod NUM_REQS and wraps.
  - Grant is possible only when count<DEPTH and flush=0.
  - in_ready[g]=1 for the granted channel only. All bits are 0 when full or flushing.
  - in_ready never depends on out_ready: no combinational path from out_ready to in_ready.
- Accept (in_valid[g]&in_ready[g]):
  - rr←g.
  - If in_tmask[g]==0: not enqueued, perf_drop++.
  - Else: {tmask,data,g} written at wr, wr++ (wraps at DEPTH).
- Dequeue: out_valid = count!=0. On out_valid&out_ready, rd++ (wraps).
- Latency: enqueue at edge N makes out_valid=1 after edge N (1 cycle). No bypass.
- Count:
  - +1 on enqueue only, −1 on dequeue only.
  - Unchanged on simultaneous enqueue+dequeue, which is legal when count<DEPTH.
- Full, out_ready=1: no enqueue this cycle; dequeue proceeds; in_ready rises next cycle.
- Empty: out_valid=0. out_tmask, out_data and out_sel are driven 0 whenever out_valid=0.
- Flush=1 (synchronous):
  - Next edge: count=0, rd=wr=0; any dequeue handshake that cycle is ignored.
  - in_ready=0 during the flush cycle.
  - rr and perf counters are preserved.
- perf_stall: +1 each cycle where |in_valid=1 and no accept occurs (includes full and flush cycles).
- Perf counters saturate at 32'hFFFFFFFF.
- Input stability: a channel holding in_valid=1 without ready must keep its payload stable. The block does not check this.

Decomposition:
- Package gpu_req_pkg holds:
  - field widths (UUID_W, NW_W, NT_W, XLEN, INST_GPU_BITS, INST_MOD_BITS, NR_BITS);
  - REQ_DATAW;
  - field offsets for pack/unpack functions.
- Sub-module gpu_req_rr_arbiter (NUM_REQS): request vector, rr pointer and enable in; one-hot grant and index out.
- FIFO storage stays inline.

Test Plan:
1. Single channel 0 valid, tmask=4'b1011, data=D0, out_ready=1.
   - in_ready[0]=1 cycle 0; out_valid=1 next cycle with out_data=D0, out_sel=0, count=1.
   - count back to 0 after the handshake.
2. All 4 channels valid continuously, out_ready=1.
   - Grants cycle 0,1,2,3,0,…; out_sel sequence matches.
   - perf_stall stays 0.
3. out_ready=0, channel 2 valid for 6 cycles.
   - 4 accepts, then in_ready=0 and count=4.
   - perf_stall=2.
   - Raise out_ready: one dequeue per cycle, in_ready[2] rises the cycle after the first dequeue.
4. Channel 1 valid with tmask=0 for 3 accepts.
   - perf_drop=3, count=0, out_valid never asserts.
   - rr advances, so channel 2 wins next over channel 1.
5. FIFO holding 3 entries, assert flush one cycle with in_valid=4'b1111.
   - in_ready=0 that cycle; count=0 and out_valid=0 next cycle.
   - Next grant follows the preserved rr pointer.
6. Assert reset_n=0 asynchronously mid-stream with count=2.
   - Outputs go 0 immediately, count=0.
   - After release, channel 0 has priority.

Source files
------------

// File: rtl/gpu_req_pkg.sv
// GPU request package: payload field widths, packed-payload offsets and
// pack/unpack helpers shared by the request arbiter/buffer and its users.
// The payload is laid out LSB-first: wb, rd, rs3, rs2, rs1, tid, op_mod,
// op_type, next_pc, pc, wid, uuid.
package gpu_req_pkg;

  localparam int UUID_W        = 44;
  localparam int NW_W          = 2;
  localparam int NT_W          = 2;
  localparam int XLEN          = 32;
  localparam int INST_GPU_BITS = 4;
  localparam int INST_MOD_BITS = 3;
  localparam int NR_BITS       = 5;

  localparam int OFF_WB      = 0;
  localparam int OFF_RD      = OFF_WB + 1;
  localparam int OFF_RS3     = OFF_RD + NR_BITS;
  localparam int OFF_RS2     = OFF_RS3 + XLEN;
  localparam int OFF_RS1     = OFF_RS2 + XLEN;
  localparam int OFF_TID     = OFF_RS1 + XLEN;
  localparam int OFF_OP_MOD  = OFF_TID + NT_W;
  localparam int OFF_OP_TYPE = OFF_OP_MOD + INST_MOD_BITS;
  localparam int OFF_NEXT_PC = OFF_OP_TYPE + INST_GPU_BITS;
  localparam int OFF_PC      = OFF_NEXT_PC + XLEN;
  localparam int OFF_WID     = OFF_PC + XLEN;
  localparam int OFF_UUID    = OFF_WID + NW_W;
  localparam int REQ_DATAW   = OFF_UUID + UUID_W;

  typedef struct packed {
    logic [UUID_W-1:0]        uuid;
    logic [NW_W-1:0]          wid;
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          next_pc;
    logic [INST_GPU_BITS-1:0] op_type;
    logic [INST_MOD_BITS-1:0] op_mod;
    logic [NT_W-1:0]          tid;
    logic [XLEN-1:0]          rs1_data;
    logic [XLEN-1:0]          rs2_data;
    logic [XLEN-1:0]          rs3_data;
    logic [NR_BITS-1:0]       rd;
    logic                     wb;
  } gpu_req_t;

  function automatic logic [REQ_DATAW-1:0] pack_req(input gpu_req_t r);
    logic [REQ_DATAW-1:0] v;
    v = '0;
    v[OFF_UUID    +: UUID_W]        = r.uuid;
    v[OFF_WID     +: NW_W]          = r.wid;
    v[OFF_PC      +: XLEN]          = r.pc;
    v[OFF_NEXT_PC +: XLEN]          = r.next_pc;
    v[OFF_OP_TYPE +: INST_GPU_BITS] = r.op_type;
    v[OFF_OP_MOD  +: INST_MOD_BITS] = r.op_mod;
    v[OFF_TID     +: NT_W]          = r.tid;
    v[OFF_RS1     +: XLEN]          = r.rs1_data;
    v[OFF_RS2     +: XLEN]          = r.rs2_data;
    v[OFF_RS3     +: XLEN]          = r.rs3_data;
    v[OFF_RD      +: NR_BITS]       = r.rd;
    v[OFF_WB]                       = r.wb;
    return v;
  endfunction

  function automatic gpu_req_t unpack_req(input logic [REQ_DATAW-1:0] v);
    gpu_req_t r;
    r.uuid     = v[OFF_UUID    +: UUID_W];
    r.wid      = v[OFF_WID     +: NW_W];
    r.pc       = v[OFF_PC      +: XLEN];
    r.next_pc  = v[OFF_NEXT_PC +: XLEN];
    r.op_type  = v[OFF_OP_TYPE +: INST_GPU_BITS];
    r.op_mod   = v[OFF_OP_MOD  +: INST_MOD_BITS];
    r.tid      = v[OFF_TID     +: NT_W];
    r.rs1_data = v[OFF_RS1     +: XLEN];
    r.rs2_data = v[OFF_RS2     +: XLEN];
    r.rs3_data = v[OFF_RS3     +: XLEN];
    r.rd       = v[OFF_RD      +: NR_BITS];
    r.wb       = v[OFF_WB];
    return r;
  endfunction

endpackage

// File: rtl/gpu_req_rr_arbiter.sv
// Combinational round-robin arbiter. Priority starts at the channel after
// rr_ptr_i and wraps around; the result is a one-hot grant plus its index.
//   req_i         in  NUM_REQS  request vector
//   rr_ptr_i      in  SEL_W     last granted channel
//   en_i          in  1         grant allowed this cycle
//   grant_o       out NUM_REQS  one-hot grant (all 0 when nothing granted)
//   grant_idx_o   out SEL_W     index of granted channel
//   grant_valid_o out 1         a grant was issued
module gpu_req_rr_arbiter
  import gpu_req_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int SEL_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic [NUM_REQS-1:0] req_i,
  input  logic [SEL_W-1:0]    rr_ptr_i,
  input  logic                en_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [SEL_W-1:0]    grant_idx_o,
  output logic                grant_valid_o
);

  // (base + off) mod NUM_REQS, valid for any channel count
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = (int'(base) + off) % NUM_REQS;
    return SEL_W'(s);
  endfunction

  logic [SEL_W-1:0] idx;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int i = 1; i <= NUM_REQS; i++) begin
      idx = wrap_add(rr_ptr_i, i);
      if (en_i && !grant_valid_o && req_i[idx]) begin
        grant_o[idx]  = 1'b1;
        grant_idx_o   = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpu_req_arb_buffer.sv
// Round-robin arbiter plus DEPTH-entry FIFO between issue/dispatch and the
// GPU unit. Zero-thread-mask requests are accepted but discarded. Flush
// empties the FIFO; stall/drop performance counters saturate.
//   clk        in  1                     clock
//   reset_n    in  1                     async active-low reset
//   flush      in  1                     synchronous FIFO clear
//   in_valid   in  NUM_REQS              per-channel valid
//   in_tmask   in  NUM_REQS*NUM_THREADS  per-channel thread mask
//   in_data    in  NUM_REQS*REQ_DATAW    per-channel payload
//   in_ready   out NUM_REQS              per-channel accept (one-hot or 0)
//   out_valid  out 1                     head entry valid
//   out_tmask  out NUM_THREADS           head thread mask (0 when empty)
//   out_data   out REQ_DATAW             head payload (0 when empty)
//   out_sel    out SEL_W                 head source channel (0 when empty)
//   out_ready  in  1                     GPU unit accepts head
//   count      out CNT_W                 FIFO occupancy
//   perf_stall out 32                    cycles with a request but no accept
//   perf_drop  out 32                    discarded zero-mask requests
module gpu_req_arb_buffer
  import gpu_req_pkg::*;
#(
  parameter  int NUM_REQS    = 4,
  parameter  int NUM_THREADS = 4,
  parameter  int DEPTH       = 4,
  localparam int SEL_W       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            flush,
  input  logic [NUM_REQS-1:0]             in_valid,
  input  logic [NUM_REQS*NUM_THREADS-1:0] in_tmask,
  input  logic [NUM_REQS*REQ_DATAW-1:0]   in_data,
  output logic [NUM_REQS-1:0]             in_ready,
  output logic                            out_valid,
  output logic [NUM_THREADS-1:0]          out_tmask,
  output logic [REQ_DATAW-1:0]            out_data,
  output logic [SEL_W-1:0]                out_sel,
  input  logic                            out_ready,
  output logic [CNT_W-1:0]                count,
  output logic [31:0]                     perf_stall,
  output logic [31:0]                     perf_drop
);

  localparam int PTR_W = $clog2(DEPTH);

  // per-channel views of the flattened input buses
  logic [NUM_THREADS-1:0] ch_tmask [NUM_REQS];
  logic [REQ_DATAW-1:0]   ch_data  [NUM_REQS];

  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_chan
      assign ch_tmask[gi] = in_tmask[gi*NUM_THREADS +: NUM_THREADS];
      assign ch_data[gi]  = in_data[gi*REQ_DATAW +: REQ_DATAW];
    end
  endgenerate

  // state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic [31:0]      perf_stall_q, perf_stall_d;
  logic [31:0]      perf_drop_q, perf_drop_d;

  logic [NUM_THREADS-1:0] tmask_mem [DEPTH];
  logic [REQ_DATAW-1:0]   data_mem  [DEPTH];
  logic [SEL_W-1:0]       sel_mem   [DEPTH];

  // arbitration; reset_n gates the grant so in_ready is 0 while held in reset
  logic [NUM_REQS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                grant_en;

  assign grant_en = reset_n && !flush && (count_q != CNT_W'(DEPTH));

  gpu_req_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .req_i         (in_valid),
    .rr_ptr_i      (rr_q),
    .en_i          (grant_en),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign in_ready = grant;

  logic                   accept;
  logic [NUM_THREADS-1:0] acc_tmask;
  logic [REQ_DATAW-1:0]   acc_data;
  logic                   drop;
  logic                   enq;
  logic                   deq;
  logic                   head_valid;

  assign accept     = grant_valid;  // grant only goes to a valid channel
  assign acc_tmask  = ch_tmask[grant_idx];
  assign acc_data   = ch_data[grant_idx];
  assign drop       = accept && (acc_tmask == '0);
  assign enq        = accept && !drop;
  assign head_valid = (count_q != '0);
  // a dequeue handshake during flush is discarded along with the contents
  assign deq        = head_valid && out_ready && !flush;

  // storage: no reset needed, validity is tracked by count/pointers
  always_ff @(posedge clk) begin
    if (enq) begin
      tmask_mem[wr_ptr_q] <= acc_tmask;
      data_mem[wr_ptr_q]  <= acc_data;
      sel_mem[wr_ptr_q]   <= grant_idx;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rr_d         = rr_q;
    perf_stall_d = perf_stall_q;
    perf_drop_d  = perf_drop_q;

    if (accept) rr_d = grant_idx;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if ((|in_valid) && !accept && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
    if (drop && (perf_drop_q != '1))
      perf_drop_d = perf_drop_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_q         <= SEL_W'(NUM_REQS - 1);  // channel 0 wins first
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_q         <= rr_d;
      perf_stall_q <= perf_stall_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  // head outputs are forced to 0 when empty
  assign out_valid  = head_valid;
  assign out_tmask  = head_valid ? tmask_mem[rd_ptr_q] : '0;
  assign out_data   = head_valid ? data_mem[rd_ptr_q]  : '0;
  assign out_sel    = head_valid ? sel_mem[rd_ptr_q]   : '0;
  assign count      = count_q;
  assign perf_stall = perf_stall_q;
  assign perf_drop  = perf_drop_q;

endmodule

// File: tb/tb_gpu_req_arb_buffer.sv
module tb_gpu_req_arb_buffer;
  import gpu_req_pkg::*;

  localparam int N  = 4;
  localparam int T  = 4;
  localparam int DW = REQ_DATAW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic [N-1:0]    in_valid;
  logic [N*T-1:0]  in_tmask;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [T-1:0]    out_tmask;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;
  logic [2:0]      count;
  logic [31:0]     perf_stall;
  logic [31:0]     perf_drop;

  logic [T-1:0]  tm [N];
  logic [DW-1:0] dd [N];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign in_tmask[gi*T +: T]   = tm[gi];
      assign in_data[gi*DW +: DW]  = dd[gi];
    end
  endgenerate

  gpu_req_arb_buffer #(
    .NUM_REQS    (N),
    .NUM_THREADS (T),
    .DEPTH       (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_tmask   (in_tmask),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_tmask  (out_tmask),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_ready  (out_ready),
    .count      (count),
    .perf_stall (perf_stall),
    .perf_drop  (perf_drop)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // step to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk_data(input int i);
    gpu_req_t r;
    r.uuid     = UUID_W'(64'h0ABC_0000_0000 + 64'(i));
    r.wid      = NW_W'(i);
    r.pc       = 32'h8000_0000 + 32'(i * 16);
    r.next_pc  = 32'h8000_0004 + 32'(i * 16);
    r.op_type  = INST_GPU_BITS'(i + 3);
    r.op_mod   = INST_MOD_BITS'(i + 1);
    r.tid      = NT_W'(i);
    r.rs1_data = 32'h1111_0000 + 32'(i);
    r.rs2_data = 32'h2222_0000 + 32'(i);
    r.rs3_data = 32'h3333_0000 + 32'(i);
    r.rd       = NR_BITS'(i + 7);
    r.wb       = 1'b1;
    return pack_req(r);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int g_seq [8];
    logic [N-1:0] e;
    g_seq = '{1, 2, 3, 0, 1, 2, 3, 0};

    for (int i = 0; i < N; i++) begin
      tm[i] = T'(i + 1);
      dd[i] = mk_data(i);
    end
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;

    // ---- reset state (in_ready gated while held in reset)
    #12;
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_perf_stall", 256'(perf_stall), 256'(0));
    chk("rst_perf_drop", 256'(perf_drop), 256'(0));
    in_valid = '0;
    #1 reset_n = 1'b1;
    tick();

    // ---- test 1: single request on channel 0
    tm[0] = 4'b1011;
    in_valid = 4'b0001;
    out_ready = 1'b1;
    #1;
    chk("t1_in_ready", 256'(in_ready), 256'(4'b0001));
    tick();
    in_valid = '0;
    #1;
    chk("t1_out_valid", 256'(out_valid), 256'(1));
    chk("t1_out_data", 256'(out_data), 256'(mk_data(0)));
    chk("t1_out_tmask", 256'(out_tmask), 256'(4'b1011));
    chk("t1_out_sel", 256'(out_sel), 256'(0));
    chk("t1_count", 256'(count), 256'(1));
    tick();
    chk("t1_count_drain", 256'(count), 256'(0));
    chk("t1_out_valid_drain", 256'(out_valid), 256'(0));

    // ---- test 2: all channels valid; rr=0 after test 1 so channel 1 leads
    for (int i = 0; i < N; i++) tm[i] = 4'b1000 | T'(i + 1);
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      e = 4'b0001 << g_seq[k];
      chk($sformatf("t2_grant%0d", k), 256'(in_ready), 256'(e));
      if (k > 0) begin
        chk($sformatf("t2_sel%0d", k), 256'(out_sel), 256'(g_seq[k-1]));
        chk($sformatf("t2_data%0d", k), 256'(out_data), 256'(mk_data(g_seq[k-1])));
        chk($sformatf("t2_count%0d", k), 256'(count), 256'(1));
      end
      tick();
    end
    in_valid = '0;
    #1;
    chk("t2_sel_last", 256'(out_sel), 256'(0));
    chk("t2_tmask_last", 256'(out_tmask), 256'(4'b1001));
    tick();
    chk("t2_count_end", 256'(count), 256'(0));
    chk("t2_perf_stall", 256'(perf_stall), 256'(0));

    // ---- test 3: fill from channel 2 with out_ready=0
    out_ready = 1'b0;
    in_valid = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      #1;
      e = (k < 4) ? 4'b0100 : 4'b0000;
      chk($sformatf("t3_ready%0d", k), 256'(in_ready), 256'(e));
      tick();
    end
    chk("t3_count_full", 256'(count), 256'(4));
    chk("t3_perf_stall", 256'(perf_stall), 256'(2));
    out_ready = 1'b1;
    #1;
    chk("t3_ready_full_deq", 256'(in_ready), 256'(0));
    tick();
    chk("t3_count_after_deq", 256'(count), 256'(3));
    #1;
    chk("t3_ready_rise", 256'(in_ready), 256'(4'b0100));
    tick();
    chk("t3_count_enq_deq", 256'(count), 256'(3));
    in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3_drain_sel%0d", k), 256'(out_sel), 256'(2));
      tick();
    end
    chk("t3_count_empty", 256'(count), 256'(0));
    chk("t3_empty_data", 256'(out_data), 256'(0));
    chk("t3_empty_sel", 256'(out_sel), 256'(0));
    chk("t3_perf_stall_end", 256'(perf_stall), 256'(3));

    // ---- test 4: zero-mask drops on channel 1 (rr=2 -> ch1 still wins alone)
    tm[1] = '0;
    in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_ready%0d", k), 256'(in_ready), 256'(4'b0010));
      tick();
      chk($sformatf("t4_out_valid%0d", k), 256'(out_valid), 256'(0));
    end
    chk("t4_perf_drop", 256'(perf_drop), 256'(3));
    chk("t4_count", 256'(count), 256'(0));
    tm[1] = 4'b0110;
    in_valid = 4'b0110;
    #1;
    chk("t4_rr_next", 256'(in_ready), 256'(4'b0100));
    in_valid = '0;

    // ---- test 5: three entries from channel 2, then flush
    out_ready = 1'b0;
    in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) tick();
    chk("t5_count_fill", 256'(count), 256'(3));
    flush = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("t5_ready_flush", 256'(in_ready), 256'(0));
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("t5_count_flushed", 256'(count), 256'(0));
    chk("t5_out_valid_flushed", 256'(out_valid), 256'(0));
    chk("t5_rr_kept", 256'(in_ready), 256'(4'b1000));
    chk("t5_perf_stall", 256'(perf_stall), 256'(4));
    chk("t5_perf_drop", 256'(perf_drop), 256'(3));
    tick();
    chk("t5_count_after", 256'(count), 256'(1));

    // ---- test 6: async reset with two entries held
    tick();
    in_valid = '0;
    chk("t6_count_pre", 256'(count), 256'(2));
    chk("t6_head_sel", 256'(out_sel), 256'(3));
    in_valid = 4'b1111;
    reset_n = 1'b0;
    #1;
    chk("t6_count_rst", 256'(count), 256'(0));
    chk("t6_out_valid_rst", 256'(out_valid), 256'(0));
    chk("t6_out_data_rst", 256'(out_data), 256'(0));
    chk("t6_in_ready_rst", 256'(in_ready), 256'(0));
    chk("t6_stall_rst", 256'(perf_stall), 256'(0));
    #1 reset_n = 1'b1;
    #1;
    chk("t6_ready_ch0", 256'(in_ready), 256'(4'b0001));
    tick();
    in_valid = '0;
    #1;
    chk("t6_count_post", 256'(count), 256'(1));
    chk("t6_sel_post", 256'(out_sel), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
